reg_7bit_up_counter_sync: RTL and testbench
===========================================

// Module: reg_7bit_up_counter_sync
// PURPOSE
//  Synchronous up counter: the count-up counterpart of the 7-bit down counter.
//  Counts from 0 (or a loaded start value) up to a programmable terminal value, then wraps to 0.
//  Emits a one-cycle terminal-count pulse (tc) and keeps a wrap tally (wraps).
//  Sits beside the down counter as the event/period generator in the sequential library.
// PARAMETERS
//  WIDTH     7  counter width in bits (Q, load_val, limit)
//  WRAP_W    4  width of the wrap tally output
// PORTS
//  clk       in   1        rising-edge clock
//  reset     in   1        synchronous, active-high reset
//  enable    in   1        count enable; 1 = advance one step per clk
//  load      in   1        synchronous load of load_val into Q
//  load_val  in   WIDTH    start value for load
//  limit     in   WIDTH    terminal value; Q wraps to 0 after reaching it
//  Q         out  WIDTH    registered count
//  tc        out  1        registered terminal-count pulse, 1 cycle wide
//  wraps     out  WRAP_W   registered count of wraps since reset, modulo 2^WRAP_W
// BEHAVIOUR
//  - One clock, clk. reset is synchronous and active-high. All outputs are registered.
//  - reset=1 at posedge: Q=0, tc=0, wraps=0. FSM goes to IDLE. Overrides load and enable.
//  - Priority at each posedge: reset > load > enable > hold.
//  - FSM states:
//    - IDLE: after reset; Q holds 0.
//    - RUN: counting.
//    - HOLD: enable=0 after RUN.
//    - DONE: saturated stop; only when SATURATE_EN is defined.
//  - FSM transitions:
//    - IDLE->RUN on enable=1 or load=1.
//    - RUN->HOLD on enable=0.
//    - HOLD->RUN on enable=1.
//    - Any state->IDLE on reset.
//  - load=1: Q<=load_val, tc<=0, wraps unchanged, the same cycle enable is ignored. The state
//    becomes RUN if enable=1, otherwise HOLD.
//  - enable=1, load=0: if Q==limit then Q<=0, tc<=1, wraps<=wraps+1. Otherwise Q<=Q+1 mod 2^WIDTH
//    and tc<=0.
//  - enable=0, load=0: Q holds; tc<=0.
//  - Latency: Q and tc change 1 cycle after the sampling edge. tc is high for exactly the cycle
//    in which Q shows 0 after a wrap.
//  - Back-to-back wraps: with limit=0 and enable held high, Q stays 0, tc stays 1 every cycle,
//    and wraps increments every cycle.
//  - load_val>limit: count proceeds to 2^WIDTH-1, rolls naturally to 0 with no tc and no wraps
//    increment, then continues to limit normally.
//  - limit changes mid-count: compared live each cycle. If Q is already above the new limit,
//    the natural-rollover rule applies.
//  - wraps overflows silently modulo 2^WRAP_W.
//  - reset mid-count: Q=0 on the next edge, and any tc in flight is cleared.
// CONFIGURATION
//  SATURATE_EN defined:
//   - On Q==limit with enable=1: Q holds at limit, tc<=1 for one cycle only, wraps increments
//     once, and the FSM enters DONE.
//   - DONE holds Q, keeps tc=0, and ignores enable.
//   - Only load or reset leaves DONE. load -> RUN/HOLD; reset -> IDLE.
//  SATURATE_EN undefined: wrap-to-0 behaviour above; DONE state is not built.
// TESTING
//  1. reset=1 for 2 cycles with enable=1, load=1 -> Q=0, tc=0, wraps=0 throughout.
//  2. limit=5, enable=1 for 14 cycles from reset -> Q: 1,2,3,4,5,0,1,...; tc=1 exactly on each Q=0
//     after 5; wraps=2.
//  3. load=1, load_val=120, limit=10, then enable=1 -> Q: 120..127,0,1..10,0; tc=0 at rollover
//     127->0 and tc=1 at 10->0; wraps=+1.
//  4. limit=0, enable=1 for 20 cycles -> Q=0 constant, tc=1 every cycle, wraps=20 mod 16=4.
//  5. Count to Q=3, enable=0 for 5 cycles, then enable=1 -> Q holds at 3, tc=0, then resumes at 4.
//     reset at Q=7 -> Q=0 on the next edge.
//  6. SATURATE_EN, limit=4, enable=1 for 10 cycles -> Q stops at 4, one tc pulse, wraps=1.
//     Then load=1, load_val=0 -> Q=0 and counting resumes.

Source files
------------

// File: rtl/reg_7bit_up_counter_sync.sv
// rtl/reg_7bit_up_counter_sync.sv - 7-bit synchronous up counter with programmable terminal value
//
// Purpose:
//    Counts from 0 (or a loaded start value) up to limit, then wraps to 0.
//    Emits a one-cycle terminal-count pulse (tc) on each wrap and keeps a
//    modulo-2^WRAP_W tally of wraps since reset.
//
// Configuration macro:
//    SATURATE_EN - when defined, reaching limit stops the count at limit
//                  (state DONE) instead of wrapping; only load or reset
//                  leaves DONE. Undefined (default): wrap-to-0, no DONE state.
//
// Ports:
//    clk       in   1       rising-edge clock
//    reset     in   1       synchronous, active-high reset
//    enable    in   1       count enable, one step per clk
//    load      in   1       synchronous load of load_val into Q
//    load_val  in   WIDTH   start value for load
//    limit     in   WIDTH   terminal value, compared live every cycle
//    Q         out  WIDTH   registered count
//    tc        out  1       registered terminal-count pulse, 1 cycle wide
//    wraps     out  WRAP_W  registered wrap tally, modulo 2^WRAP_W

module reg_7bit_up_counter_sync #(
   parameter int WIDTH  = 7,
   parameter int WRAP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic [WIDTH-1:0]  limit,
   output logic [WIDTH-1:0]  Q,
   output logic              tc,
   output logic [WRAP_W-1:0] wraps
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
`ifdef SATURATE_EN
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
`else
      ST_HOLD = 2'd2
`endif
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [WIDTH-1:0]    q_nxt;
   logic                tc_nxt;
   logic [WRAP_W-1:0]   wraps_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         Q     <= '0;
         tc    <= 1'b0;
         wraps <= '0;
      end else begin
         state <= state_nxt;
         Q     <= q_nxt;
         tc    <= tc_nxt;
         wraps <= wraps_nxt;
      end
   end

   // Priority below reset: load > enable > hold. The count datapath does not
   // depend on the state except for DONE, so IDLE/HOLD advance on the same
   // edge that moves the FSM into RUN.
   always_comb begin
      state_nxt = state;
      q_nxt     = Q;
      tc_nxt    = 1'b0;
      wraps_nxt = wraps;

      if (load) begin
         q_nxt     = load_val;
         state_nxt = enable ? ST_RUN : ST_HOLD;
`ifdef SATURATE_EN
      end else if (state == ST_DONE) begin
         // Saturated: hold Q, keep tc low, ignore enable.
         state_nxt = ST_DONE;
`endif
      end else if (enable) begin
         state_nxt = ST_RUN;
         // Exact match only: a Q above limit rolls over naturally at
         // 2^WIDTH-1 without tc or a wraps increment.
         if (Q == limit) begin
`ifdef SATURATE_EN
            state_nxt = ST_DONE;
`else
            q_nxt     = '0;
`endif
            tc_nxt    = 1'b1;
            wraps_nxt = wraps + 1'b1;
         end else begin
            q_nxt = Q + 1'b1;
         end
      end else begin
         case (state)
            ST_RUN:  state_nxt = ST_HOLD;
            default: state_nxt = state;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_7bit_up_counter_sync.sv
// tb/tb_reg_7bit_up_counter_sync.sv - scoreboard bench for reg_7bit_up_counter_sync

module tb_reg_7bit_up_counter_sync;

   localparam int WIDTH  = 7;
   localparam int WRAP_W = 4;
   localparam int QMOD   = 1 << WIDTH;
   localparam int WMOD   = 1 << WRAP_W;
`ifdef SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              load = 1'b0;
   logic [WIDTH-1:0]  load_val = '0;
   logic [WIDTH-1:0]  limit = '0;
   logic [WIDTH-1:0]  Q;
   logic              tc;
   logic [WRAP_W-1:0] wraps;

   typedef struct {
      int q;
      int tc;
      int w;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   int m_q    = 0;
   int m_tc   = 0;
   int m_w    = 0;
   bit m_done = 1'b0;

   reg_7bit_up_counter_sync #(.WIDTH(WIDTH), .WRAP_W(WRAP_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .load     (load),
      .load_val (load_val),
      .limit    (limit),
      .Q        (Q),
      .tc       (tc),
      .wraps    (wraps)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of stimulus and push the model's prediction for the
   // following posedge.
   task automatic step(input bit r, input bit e, input bit l, input int lv, input int lim);
      exp_t x;
      @(negedge clk);
      reset    = r;
      enable   = e;
      load     = l;
      load_val = WIDTH'(lv);
      limit    = WIDTH'(lim);
      if (r) begin
         m_q = 0; m_tc = 0; m_w = 0; m_done = 1'b0;
      end else if (l) begin
         m_q = lv % QMOD; m_tc = 0; m_done = 1'b0;
      end else if (e && !m_done) begin
         if (m_q == lim) begin
            m_tc = 1;
            m_w  = (m_w + 1) % WMOD;
            if (SAT) m_done = 1'b1;
            else     m_q = 0;
         end else begin
            m_q  = (m_q + 1) % QMOD;
            m_tc = 0;
         end
      end else begin
         m_tc = 0;
      end
      x.q = m_q; x.tc = m_tc; x.w = m_w;
      sb.push_back(x);
   endtask

   task automatic steps(input int n, input bit e, input int lim);
      for (int i = 0; i < n; i++) step(1'b0, e, 1'b0, 0, lim);
   endtask

   // Sample the DUT just after the posedge that follows the last step.
   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   // Monitor: every clock the DUT presents a new registered output.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         mon_e = sb.pop_front();
         check("sb_q",     32'(Q),     mon_e.q);
         check("sb_tc",    32'(tc),    mon_e.tc);
         check("sb_wraps", 32'(wraps), mon_e.w);
      end
   end

   initial begin
      // 1: reset held with enable and load asserted
      step(1'b1, 1'b1, 1'b1, 77, 5);
      step(1'b1, 1'b1, 1'b1, 77, 5);
      settle();
      check("reset_q", 32'(Q), 0);
      check("reset_tc", 32'(tc), 0);
      check("reset_wraps", 32'(wraps), 0);

`ifndef SATURATE_EN
      // 2: limit=5, 14 enabled cycles
      step(1'b1, 1'b0, 1'b0, 0, 5);
      steps(14, 1'b1, 5);
      settle();
      check("lim5_q", 32'(Q), 2);
      check("lim5_wraps", 32'(wraps), 2);

      // 3: load 120 above limit 10, natural rollover then terminal wrap
      step(1'b1, 1'b0, 1'b0, 0, 10);
      step(1'b0, 1'b0, 1'b1, 120, 10);
      steps(19, 1'b1, 10);
      settle();
      check("over_q", 32'(Q), 0);
      check("over_tc", 32'(tc), 1);
      check("over_wraps", 32'(wraps), 1);

      // 4: limit=0 back-to-back wraps
      step(1'b1, 1'b0, 1'b0, 0, 0);
      steps(20, 1'b1, 0);
      settle();
      check("lim0_q", 32'(Q), 0);
      check("lim0_tc", 32'(tc), 1);
      check("lim0_wraps", 32'(wraps), 4);
`endif

      // 5: hold then resume, reset mid-count
      step(1'b1, 1'b0, 1'b0, 0, 100);
      steps(3, 1'b1, 100);
      steps(5, 1'b0, 100);
      settle();
      check("hold_q", 32'(Q), 3);
      check("hold_tc", 32'(tc), 0);
      steps(4, 1'b1, 100);
      settle();
      check("resume_q", 32'(Q), 7);
      step(1'b1, 1'b1, 1'b0, 0, 100);
      settle();
      check("midreset_q", 32'(Q), 0);

`ifdef SATURATE_EN
      // 6: saturate at limit, then reload
      step(1'b1, 1'b0, 1'b0, 0, 4);
      steps(10, 1'b1, 4);
      settle();
      check("sat_q", 32'(Q), 4);
      check("sat_tc", 32'(tc), 0);
      check("sat_wraps", 32'(wraps), 1);
      step(1'b0, 1'b0, 1'b1, 0, 4);
      steps(3, 1'b1, 4);
      settle();
      check("sat_reload_q", 32'(Q), 3);
`endif

      // Randomized phase against the model
      step(1'b1, 1'b0, 1'b0, 0, 0);
      begin
         int lim = 0;
         for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0)
               lim = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 127))
                                                  : int'($urandom_range(0, 12));
            step(r < 1, $urandom_range(0, 3) != 0, (r >= 1) && (r < 5),
                 int'($urandom_range(0, 127)), lim);
         end
      end
      settle();
      @(posedge clk);
      #3;
      check("sb_drained", 32'(sb.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
